// File: rtl/row_window_buffer_pkg.sv
// row_window_buffer_pkg: shared state encoding, defaults and window indexing
package row_window_buffer_pkg;

    localparam int BW_DEF      = 32;
    localparam int IM_SIZE_DEF = 32;
    localparam int K_DEF       = 3;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        IDLE = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // flat element index of window element (r,c); r=0 oldest row, c=0 leftmost column
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/row_window_buffer_window_col_mux.sv
// window_col_mux: selects the KxK window at a given left column from K buffered rows
module window_col_mux
    import row_window_buffer_pkg::*;
#(
    parameter int  BW      = BW_DEF,
    parameter int  IM_SIZE = IM_SIZE_DEF,
    parameter int  K       = K_DEF,
    localparam int CW      = $clog2(IM_SIZE)
) (
    input  logic [IM_SIZE*BW-1:0] rows_i [K],
    input  logic [CW-1:0]         col_i,
    output logic [K*K*BW-1:0]     win_o
);

    // image column c sits at word IM_SIZE-1-c, so shift that word down to bit 0
    always_comb begin
        win_o = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                win_o[win_idx(r, c, K)*BW +: BW] = BW'(rows_i[r] >> (BW * (IM_SIZE - 1 - c - int'(col_i))));
    end

endmodule

// File: rtl/row_window_buffer.sv
// row_window_buffer: K-row line buffer that sweeps KxK convolution windows over each row
module row_window_buffer
    import row_window_buffer_pkg::*;
#(
    parameter int  BW      = BW_DEF,
    parameter int  IM_SIZE = IM_SIZE_DEF,
    parameter int  K       = K_DEF,
    localparam int CW      = $clog2(IM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  row_valid,
    input  logic [IM_SIZE*BW-1:0] row_in,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [K*K*BW-1:0]     win_data,
    output logic [CW-1:0]         win_col,
    output logic [CW-1:0]         win_row,
    output logic                  win_last,
    output logic                  busy,
    output logic                  overflow,
    output logic                  frame_done
);

    localparam int            RW   = $clog2(K + 1);
    localparam logic [CW-1:0] LAST = CW'(IM_SIZE - K);
    localparam logic [RW-1:0] KR   = RW'(K);

    state_t                state_q, state_d;
    logic [RW-1:0]         rows_q, rows_d;
    logic [CW-1:0]         col_q, col_d;
    logic [CW-1:0]         out_row_q, out_row_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_done_q, frame_done_d;
    logic                  accept;
    logic [IM_SIZE*BW-1:0] line_q [K];

    assign busy      = (state_q == EMIT) || (state_q == DONE);
    assign accept    = row_valid && !busy && !frame_start;
    assign win_valid = (state_q == EMIT);
    assign win_col   = col_q;
    assign win_row   = out_row_q;
    assign win_last  = win_valid && (col_q == LAST) && (out_row_q == LAST);
    assign overflow  = overflow_q;
    assign frame_done = frame_done_q;

    window_col_mux #(.BW(BW), .IM_SIZE(IM_SIZE), .K(K)) u_mux (
        .rows_i (line_q),
        .col_i  (col_q),
        .win_o  (win_data)
    );

    // next-state: frame_start overrides everything, then row accept, then window handshake
    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        col_d        = col_q;
        out_row_d    = out_row_q;
        overflow_d   = overflow_q || (row_valid && busy && !frame_start);
        frame_done_d = 1'b0;
        if (frame_start) begin
            state_d    = FILL;
            rows_d     = '0;
            col_d      = '0;
            out_row_d  = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            rows_d = (rows_q == KR) ? KR : rows_q + 1'b1;
            if (rows_q >= KR - 1'b1) begin
                state_d = EMIT;
                col_d   = '0;
            end
        end else if (state_q == EMIT && win_ready) begin
            if (col_q != LAST) begin
                col_d = col_q + 1'b1;
            end else if (out_row_q == LAST) begin
                state_d      = DONE;
                frame_done_d = 1'b1;
            end else begin
                out_row_d = out_row_q + 1'b1;
                state_d   = IDLE;
            end
        end
    end

    // control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            rows_q       <= '0;
            col_q        <= '0;
            out_row_q    <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            col_q        <= col_d;
            out_row_q    <= out_row_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    // line buffer: oldest row at index 0, newest accepted row enters at K-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < K; r++)
                line_q[r] <= '0;
        end else if (accept) begin
            for (int r = 0; r < K - 1; r++)
                line_q[r] <= line_q[r+1];
            line_q[K-1] <= row_in;
        end
    end

endmodule

// File: doc/row_window_buffer.md
Name: row_window_buffer

Overview:
- Sits directly downstream of the ROM row-shifter stage.
- Captures each completed image row (parallel IM_SIZE-word vector, qualified by the shifter's one-cycle full-row pulse) into a K-row line buffer.
- Once K rows are held, sweeps the columns and emits KxK convolution windows to the MAC/convolution stage over a valid/ready handshake.
- Tracks frame position and flags rows that arrive while it cannot accept them.

Parameters:
- BW, 32, bits per pixel word.
- IM_SIZE, 32, pixels per row and rows per frame.
- K, 3, window (kernel) size; 2 <= K <= IM_SIZE.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse; starts a new frame (driven by the next-sample button path).
- row_valid  in  1  one-cycle pulse; row_in holds a complete row.
- row_in  in  IM_SIZE*BW  row words; word i = row_in[i*BW +: BW]; image column c is word IM_SIZE-1-c (newest-shifted word is word 0).
- win_valid  out  1  window available.
- win_ready  in  1  consumer accepts the window.
- win_data  out  K*K*BW  element (r,c) at [(r*K+c)*BW +: BW]; r=0 is the oldest row, c=0 is the leftmost column.
- win_col  out  clog2(IM_SIZE)  column of the window's left edge.
- win_row  out  clog2(IM_SIZE)  row of the window's top edge within the frame.
- win_last  out  1  high with the final window of the frame.
- busy  out  1  high in EMIT or DONE; rows are not accepted.
- overflow  out  1  sticky: a row arrived while busy.
- frame_done  out  1  one-cycle pulse after the final window handshake.

Behaviour:
- Reset (async, rst=0):
  - State = FILL; rows_stored, col and out_row = 0.
  - All outputs 0; line buffer cleared to 0.
- States:
  - FILL: fewer than K rows held.
  - IDLE: K rows held, waiting for the next row.
  - EMIT: sweeping columns.
  - DONE: frame complete.
- Row accept (FILL or IDLE, row_valid=1):
  - Line buffer shifts: buf[r] <= buf[r+1], buf[K-1] <= row_in.
  - rows_stored increments, saturating at K.
  - If K rows are now held, go to EMIT with col=0; win_valid rises the cycle after row_valid.
- EMIT:
  - win_valid=1.
  - win_data is taken from buf columns col..col+K-1 and stays stable while win_valid=1 and win_ready=0.
  - On a handshake (win_valid & win_ready) with col < IM_SIZE-K: col+1.
  - On a handshake with col == IM_SIZE-K:
    - If out_row == IM_SIZE-K: go to DONE and pulse frame_done next cycle.
    - Otherwise: out_row+1 and go to IDLE.
  - win_valid drops the cycle after the last handshake of a row.
  - win_ready held high yields IM_SIZE-K+1 windows in consecutive cycles. That is 30 at the defaults, which fits inside the upstream 35-cycle row cadence.
- win_last = win_valid & (col == IM_SIZE-K) & (out_row == IM_SIZE-K).
- DONE: hold until frame_start; no windows are emitted.
- Busy rows: row_valid in EMIT or DONE is dropped, sets overflow, and leaves the buffer unchanged.
- frame_start (any state, highest priority):
  - Next state FILL; rows_stored, col and out_row = 0.
  - overflow cleared; win_valid = 0 next cycle.
  - Line buffer contents are retained but unused.
  - row_valid in the same cycle is dropped without setting overflow.
- A mid-EMIT frame_start aborts the sweep; the in-flight window is not emitted.
- Counter widths: col and out_row are clog2(IM_SIZE) bits and never exceed IM_SIZE-K.

Decomposition:
- Shared package (header):
  - State encodings FILL=0, IDLE=1, EMIT=2, DONE=3.
  - Defaults for BW, IM_SIZE, K.
  - Window element index macro.
- One natural sub-module, window_col_mux: combinational selection of the KxK window from the K buffered rows given col.

Test Plan:
- Fill and first window: rows of pixel value 100*row+col, K=3; three row_valid pulses 35 cycles apart, win_ready=1 → win_valid one cycle after the third pulse; first window elements 0,1,2 / 100,101,102 / 200,201,202 (r,c order); 30 consecutive windows; win_col 0..29; win_row=0.
- Backpressure: hold win_ready=0 for 5 cycles at col=4 → win_valid stays 1; win_data and win_col=4 stable; after release, col 5 follows the next cycle.
- Overflow: row_valid while col=10 in EMIT → row dropped; overflow=1 stays set; the next window is still row-0 data at col 11; a later frame_start clears overflow.
- Full frame: 32 rows, win_ready=1 → 30x30=900 windows; win_last only on (row 29, col 29); frame_done pulses one cycle later; busy=1 in DONE; a 33rd row sets overflow.
- Abort: frame_start at col=15, row 2 → win_valid=0 next cycle; state FILL; the next three rows restart with win_row=0, win_col=0.
- Reset mid-EMIT: drive rst=0 asynchronously → win_valid, busy, overflow, frame_done all 0 immediately; after release, behaviour matches a fresh FILL.
